// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state codes and parity-mode encodings for the configurable UART transmitter
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous transmit FIFO, show-ahead read port, sync active-high reset
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers are AW bits wide so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter (width, parity, stop bits, baud divisor)
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry transmit FIFO in front of the serializer.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_vld,
  output logic              tx_rdy,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic              tx_busy,
  output logic              uart_tx
);

  localparam int BIT_CW = $clog2(DATA_W);

  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [BIT_CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        par_q, par_d;
  logic              stop2_q, stop2_d;
  logic              uart_tx_q, uart_tx_d;

  logic              start_go;
  logic [DATA_W-1:0] start_word;
  logic [DIV_W-1:0]  div_m1;
  logic              bit_end;
  logic              par_bit;

`ifdef UART_TX_FIFO_EN
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign tx_rdy     = !fifo_full && !rst;
  assign start_go   = (state_q == ST_IDLE) && !fifo_empty;
  assign start_word = fifo_rdata;

  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_vld && tx_rdy),
    .wdata (tx_data),
    .pop   (start_go),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  assign tx_rdy     = (state_q == ST_IDLE) && !rst;
  assign start_go   = tx_vld && tx_rdy;
  assign start_word = tx_data;
`endif

  // A divisor of zero behaves as one clock per bit.
  assign div_m1  = (div_q == '0) ? '0 : div_q - 1'b1;
  assign bit_end = (baud_cnt_q == div_m1);
  assign par_bit = (^data_q) ^ (par_q == PAR_ODD);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    div_d      = div_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (start_go) begin
          state_d = ST_START;
          data_d  = start_word;
          div_d   = baud_div;
          par_d   = parity_mode;
          stop2_d = stop2;
        end
      end
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_CW'(DATA_W-1)) begin
            bit_cnt_d = '0;
            state_d   = par_enabled(par_q) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP: begin
        // bit_cnt doubles as the stop-bit index when two stop bits are latched.
        if (bit_end) begin
          if (stop2_q && bit_cnt_q == '0) begin
            bit_cnt_d = BIT_CW'(1);
          end else begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  uart_tx_d = 1'b0;
      ST_DATA:   uart_tx_d = data_d[bit_cnt_d];
      ST_PARITY: uart_tx_d = par_bit;
      default:   uart_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      div_q      <= '0;
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
      uart_tx_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      div_q      <= div_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      uart_tx_q  <= uart_tx_d;
    end
  end

  assign tx_busy = (state_q != ST_IDLE);
  assign uart_tx = uart_tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg (8-bit and 7-bit instances)
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  tx_data;
  logic        tx_vld;
  logic        sel;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;

  logic a_rdy, a_busy, a_tx;
  logic b_rdy, b_busy, b_tx;
  logic cur_rdy, cur_busy, cur_tx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_W(8), .DIV_W(16), .FIFO_DEPTH(4)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data[7:0]),
    .tx_vld      (tx_vld && !sel),
    .tx_rdy      (a_rdy),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx_busy     (a_busy),
    .uart_tx     (a_tx)
  );

  uart_tx_cfg #(.DATA_W(7), .DIV_W(16), .FIFO_DEPTH(4)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data[6:0]),
    .tx_vld      (tx_vld && sel),
    .tx_rdy      (b_rdy),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx_busy     (b_busy),
    .uart_tx     (b_tx)
  );

  assign cur_rdy  = sel ? b_rdy  : a_rdy;
  assign cur_busy = sel ? b_busy : a_busy;
  assign cur_tx   = sel ? b_tx   : a_tx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one word, swaps in div_mid/pm_mid right after the transfer, then
  // captures one line sample per bit period until tx_busy falls.
  task automatic run_frame(input logic [8:0] word, input logic s, input int div,
                           input logic [1:0] pm, input logic s2, input int div_mid,
                           input logic [1:0] pm_mid, output logic [15:0] line,
                           output int busy_cnt);
    int p;
    p = (div == 0) ? 1 : div;
    @(negedge clk);
    sel = s; tx_data = word; baud_div = 16'(div); parity_mode = pm; stop2 = s2; tx_vld = 1'b1;
    @(posedge clk);
    #1;
    tx_vld = 1'b0; baud_div = 16'(div_mid); parity_mode = pm_mid;
    line = '0;
    busy_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!cur_busy) break;
      if ((c % p) == 0 && (c / p) < 16) line[c/p] = cur_tx;
      busy_cnt++;
    end
  endtask

  initial begin
    logic [15:0] line;
    int busy_cnt;
    int r1, r2;
    logic prev;
    logic rdy_seen;

    rst = 1'b1; tx_data = '0; tx_vld = 1'b0; sel = 1'b0;
    baud_div = 16'd4; parity_mode = 2'b00; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_a", a_tx, 1);
    chk("rst_busy_a", a_busy, 0);
    chk("rst_rdy_a", a_rdy, 0);
    chk("rst_tx_b", b_tx, 1);
    chk("rst_rdy_b", b_rdy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rdy_a", a_rdy, 1);

`ifdef UART_TX_FIFO_EN
    begin
      int pushed, first_low, rx_cnt, fcnt, idle_run;
      logic pend, in_frame;
      logic [7:0] sh;
      logic [7:0] rx_words [6];
      pushed = 0; first_low = -1; rx_cnt = 0; fcnt = 0; idle_run = 0;
      pend = 1'b0; in_frame = 1'b0; sh = '0;
      sel = 1'b0; baud_div = 16'd2; parity_mode = 2'b00; stop2 = 1'b0;
      tx_data = 9'h01; tx_vld = 1'b1;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (pend) begin
          pushed++;
          if (pushed < 6) tx_data = 9'(pushed + 1);
          else tx_vld = 1'b0;
        end
        if (tx_vld && !a_rdy && first_low < 0) first_low = pushed;
        pend = tx_vld && a_rdy;
        if (in_frame) begin
          fcnt++;
          if ((fcnt % 2) == 0 && fcnt >= 2 && fcnt <= 16) sh[fcnt/2-1] = a_tx;
          if (fcnt == 19) begin
            if (rx_cnt < 6) rx_words[rx_cnt] = sh;
            rx_cnt++;
            in_frame = 1'b0;
          end
        end else if (a_tx == 1'b0) begin
          in_frame = 1'b1;
          fcnt = 0;
        end
        if (rx_cnt > 0) begin
          if (!a_busy) idle_run++;
          else if (idle_run > 0) begin
            chk("fifo_gap", idle_run, 1);
            idle_run = 0;
          end
        end
        if (rx_cnt >= 6 && !a_busy) break;
      end
      chk("fifo_full_at", first_low, 5);
      chk("fifo_pushed", pushed, 6);
      chk("fifo_rx_cnt", rx_cnt, 6);
      for (int i = 0; i < 6; i++) chk("fifo_word", (i < rx_cnt) ? rx_words[i] : 8'hxx, i + 1);
    end
`else
    run_frame(9'h0A5, 1'b0, 4, 2'b01, 1'b0, 4, 2'b01, line, busy_cnt);
    chk("a5_even_line", line, 16'h054A);
    chk("a5_even_busy", busy_cnt, 44);

    run_frame(9'h007, 1'b1, 3, 2'b10, 1'b1, 3, 2'b10, line, busy_cnt);
    chk("w7_odd_line", line, 16'h060E);
    chk("w7_odd_busy", busy_cnt, 33);

    run_frame(9'h03C, 1'b0, 0, 2'b00, 1'b0, 0, 2'b00, line, busy_cnt);
    chk("div0_line", line, 16'h0278);
    chk("div0_busy", busy_cnt, 10);

    @(negedge clk);
    sel = 1'b0; tx_data = 9'h03C; baud_div = 16'd0; parity_mode = 2'b11; stop2 = 1'b0; tx_vld = 1'b1;
    r1 = -1; r2 = -1; prev = 1'b0; rdy_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (a_busy && !prev) begin
        if (r1 < 0) r1 = c;
        else if (r2 < 0) r2 = c;
      end
      if (!a_busy && r1 >= 0 && r2 < 0 && !rdy_seen) begin
        chk("b2b_idle_rdy", a_rdy, 1);
        rdy_seen = 1'b1;
      end
      prev = a_busy;
    end
    tx_vld = 1'b0;
    chk("b2b_period", r2 - r1, 11);
    for (int c = 0; c < 40 && a_busy; c++) @(negedge clk);

    run_frame(9'h0A5, 1'b0, 4, 2'b01, 1'b0, 8, 2'b10, line, busy_cnt);
    chk("mid_chg_line", line, 16'h054A);
    chk("mid_chg_busy", busy_cnt, 44);
    run_frame(9'h0A5, 1'b0, 8, 2'b10, 1'b0, 8, 2'b10, line, busy_cnt);
    chk("new_cfg_line", line, 16'h074A);
    chk("new_cfg_busy", busy_cnt, 88);

    @(negedge clk);
    sel = 1'b0; tx_data = 9'h0A5; baud_div = 16'd4; parity_mode = 2'b01; tx_vld = 1'b1;
    @(posedge clk);
    #1 tx_vld = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", a_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_tx", a_tx, 1);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_rdy", a_rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", a_rdy, 1);
    run_frame(9'h03C, 1'b0, 0, 2'b00, 1'b0, 0, 2'b00, line, busy_cnt);
    chk("post_rst_line", line, 16'h0278);
    chk("post_rst_busy", busy_cnt, 10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
